// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard stall, EX flush
//            handling and saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_AluASrc,
  input  logic             id_AluBSrc,
  input  logic             id_RuWr,
  input  logic [3:0]       id_ALUOp,
  input  logic [4:0]       id_BrOp,
  input  logic             id_DMWr,
  input  logic [2:0]       id_DMCtrl,
  input  logic [1:0]       id_RUDataWrSrc,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_flush,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_AluASrc,
  output logic             ex_AluBSrc,
  output logic             ex_RuWr,
  output logic [3:0]       ex_ALUOp,
  output logic [4:0]       ex_BrOp,
  output logic             ex_DMWr,
  output logic [2:0]       ex_DMCtrl,
  output logic [1:0]       ex_RUDataWrSrc,
  output logic             ex_use_rs1,
  output logic             ex_use_rs2,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] c_SRC_LOAD = 2'b01;

  logic             r_valid;
  logic             r_AluASrc;
  logic             r_AluBSrc;
  logic             r_RuWr;
  logic [3:0]       r_ALUOp;
  logic [4:0]       r_BrOp;
  logic             r_DMWr;
  logic [2:0]       r_DMCtrl;
  logic [1:0]       r_RUDataWrSrc;
  logic             r_use_rs1;
  logic             r_use_rs2;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_hazard;
  logic w_stall;
  logic w_bubble;

  // Load in EX whose result is consumed by the instruction in ID
  assign w_hazard = r_valid & r_RuWr & (r_RUDataWrSrc == c_SRC_LOAD) &
                    (r_rd != 5'd0) & id_valid &
                    ((id_use_rs1 & (id_rs1 == r_rd)) |
                     (id_use_rs2 & (id_rs2 == r_rd)));
  assign w_stall  = w_hazard & ~ex_flush;
  assign w_bubble = ex_flush | w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_AluASrc     <= 1'b0;
      r_AluBSrc     <= 1'b0;
      r_RuWr        <= 1'b0;
      r_ALUOp       <= '0;
      r_BrOp        <= '0;
      r_DMWr        <= 1'b0;
      r_DMCtrl      <= '0;
      r_RUDataWrSrc <= '0;
      r_use_rs1     <= 1'b0;
      r_use_rs2     <= 1'b0;
      r_pc          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (w_bubble) begin
        r_valid       <= 1'b0;
        r_AluASrc     <= 1'b0;
        r_AluBSrc     <= 1'b0;
        r_RuWr        <= 1'b0;
        r_ALUOp       <= '0;
        r_BrOp        <= '0;
        r_DMWr        <= 1'b0;
        r_DMCtrl      <= '0;
        r_RUDataWrSrc <= '0;
        r_use_rs1     <= 1'b0;
        r_use_rs2     <= 1'b0;
      end else begin
        // A bubble arriving from IF/ID must not carry live control bits
        r_valid       <= id_valid;
        r_AluASrc     <= id_valid & id_AluASrc;
        r_AluBSrc     <= id_valid & id_AluBSrc;
        r_RuWr        <= id_valid & id_RuWr;
        r_ALUOp       <= id_valid ? id_ALUOp : 4'd0;
        r_BrOp        <= id_valid ? id_BrOp : 5'd0;
        r_DMWr        <= id_valid & id_DMWr;
        r_DMCtrl      <= id_valid ? id_DMCtrl : 3'd0;
        r_RUDataWrSrc <= id_valid ? id_RUDataWrSrc : 2'd0;
        r_use_rs1     <= id_valid & id_use_rs1;
        r_use_rs2     <= id_valid & id_use_rs2;
        r_pc          <= id_pc;
        r_rs1_data    <= id_rs1_data;
        r_rs2_data    <= id_rs2_data;
        r_imm         <= id_imm;
        r_rs1         <= id_rs1;
        r_rs2         <= id_rs2;
        r_rd          <= id_rd;
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (ex_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall          = w_stall;
  assign ex_valid       = r_valid;
  assign ex_AluASrc     = r_AluASrc;
  assign ex_AluBSrc     = r_AluBSrc;
  assign ex_RuWr        = r_RuWr;
  assign ex_ALUOp       = r_ALUOp;
  assign ex_BrOp        = r_BrOp;
  assign ex_DMWr        = r_DMWr;
  assign ex_DMCtrl      = r_DMCtrl;
  assign ex_RUDataWrSrc = r_RUDataWrSrc;
  assign ex_use_rs1     = r_use_rs1;
  assign ex_use_rs2     = r_use_rs2;
  assign ex_pc          = r_pc;
  assign ex_rs1_data    = r_rs1_data;
  assign ex_rs2_data    = r_rs2_data;
  assign ex_imm         = r_imm;
  assign ex_rs1         = r_rs1;
  assign ex_rs2         = r_rs2;
  assign ex_rd          = r_rd;
  assign stall_count    = r_stall_cnt;
  assign flush_count    = r_flush_cnt;

endmodule

`default_nettype wire
